// File: rtl/trace_tx_buffer.sv
// Trace byte FIFO feeding a UART transmitter, with overflow accounting and a one-shot
// overflow marker byte inserted into the stream after data loss.
module trace_tx_buffer #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter logic [7:0]  OVF_MARKER   = 8'hA5,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    input  logic                  tx_busy,
    input  logic                  clr_ovf,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {Idle, Start, WaitBusy, WaitDone} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              rst_sync_q;
    logic                    run;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic                    marker_pending_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    full, empty, pop, push_data, push_mark, wr_en, drop;
    logic [7:0]              wr_data;
    logic                    tx_start_d, cnt_clr, cnt_inc;

    // Logic stays inert until reset release has passed through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    assign full      = level[DEPTH_LOG2];
    assign empty     = (level == '0);
    assign push_data = run && in_valid && (!full || pop);
    assign drop      = run && in_valid && full && !pop;
    assign push_mark = run && marker_pending_q && !in_valid && !full;
    assign wr_en     = push_data || push_mark;
    assign wr_data   = in_valid ? in_byte : OVF_MARKER;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level            <= '0;
            marker_pending_q <= 1'b0;
            ovf              <= 1'b0;
            drop_count       <= 8'h00;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            if (wr_en && !pop)      level <= level + (DEPTH_LOG2 + 1)'(1);
            else if (!wr_en && pop) level <= level - (DEPTH_LOG2 + 1)'(1);
            if (drop)           marker_pending_q <= 1'b1;
            else if (push_mark) marker_pending_q <= 1'b0;
            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                ovf <= 1'b1;
                if (clr_ovf)                  drop_count <= 8'd1;
                else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (clr_ovf) begin
                ovf        <= 1'b0;
                drop_count <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= Idle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle:     if (pop) state_d = Start;
            Start:    state_d = WaitBusy;
            WaitBusy: begin
                if (tx_busy)                                state_d = WaitDone;
                else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) state_d = Idle;
            end
            WaitDone: if (!tx_busy) state_d = Idle;
            default:  state_d = Idle;
        endcase
    end

    always_comb begin
        pop        = run && (state_q == Idle) && !empty;
        tx_start_d = (state_q == Start);
        cnt_clr    = (state_q == Start);
        cnt_inc    = (state_q == WaitBusy) && !tx_busy;
    end

    // tx_start is registered, so it rises the cycle after Start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start <= 1'b0;
            tx_byte  <= 8'h00;
            cnt_q    <= '0;
        end else begin
            tx_start <= tx_start_d;
            if (pop) tx_byte <= mem_q[rd_ptr_q];
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trace_tx_buffer.sv
// Directed bench for trace_tx_buffer: expected UART bytes are queued at stimulus time and
// checked by a monitor on every tx_start; a behavioural UART drives tx_busy.
module tb_trace_tx_buffer;

    localparam int GAP = 2 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [4:0] level;
    logic       ovf;
    logic [7:0] drop_count;

    trace_tx_buffer #(
        .DEPTH_LOG2   (4),
        .OVF_MARKER   (8'hA5),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .tx_busy    (tx_busy),
        .clr_ovf    (clr_ovf),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .level      (level),
        .ovf        (ovf),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_start = 0;
    int         mode = 0;       // 0: busy low, 1: UART-like pulse, 2: busy held high
    bit         chk_gap = 1'b0;
    int         last_start = -1;
    int         snap;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every tx_start must carry the next expected byte.
    always @(negedge clk) begin
        if (!chk_gap) last_start = -1;
        if (rst && tx_start) begin
            n_start++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx_start: got byte %0h, none expected", tx_byte);
            end else begin
                check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
            end
            if (chk_gap) begin
                if (last_start >= 0) check("start_gap", cyc - last_start, GAP);
                last_start = cyc;
            end
        end
    end

    // UART model: in mode 1, busy rises 2 cycles after tx_start and stays up 10 cycles.
    initial begin
        int dly = 0;
        int hi = 0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: begin tx_busy = 1'b0; dly = 0; hi = 0; end
                2: tx_busy = 1'b1;
                default: begin
                    if (hi > 0) hi--;
                    if (tx_start) dly = 2;
                    else if (dly > 0) begin
                        dly--;
                        if (dly == 0) hi = 10;
                    end
                    tx_busy = (hi > 0);
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #3;
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_count, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        rst = 1'b1;
        repeat (4) tick();

        // Single byte with UART-like busy pulse, plus push-to-start latency
        mode = 1;
        in_valid = 1'b1;
        in_byte = 8'h3C;
        exp_q.push_back(8'h3C);
        tick();
        in_valid = 1'b0;
        check("lat_k", tx_start, 0);
        tick();
        check("lat_k1", tx_start, 0);
        tick();
        check("lat_k2", tx_start, 1);
        repeat (30) tick();
        check("single_level", level, 0);
        check("single_starts", n_start, 1);
        check("single_q", exp_q.size(), 0);

        // Burst of 20 with busy held high: 17 stored incl. the popped one, 3 dropped
        mode = 2;
        tick();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_byte = 8'(i);
            if (i <= 16) exp_q.push_back(8'(i));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("burst_level", level, 16);
        check("burst_drop", drop_count, 3);
        check("burst_ovf", ovf, 1);

        // Release busy; push coincides with the first pop while full
        tick();
        mode = 0;
        chk_gap = 1'b1;
        tick();
        in_valid = 1'b1;
        in_byte = 8'h77;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'hA5);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("pushpop_level", level, 16);
        check("pushpop_drop", drop_count, 3);

        // Drop and clear in the same cycle, then clear alone
        in_valid = 1'b1;
        in_byte = 8'hEE;
        clr_ovf = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("clrdrop_ovf", ovf, 1);
        check("clrdrop_cnt", drop_count, 1);
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("clr_ovf", ovf, 0);
        check("clr_cnt", drop_count, 0);

        // Drain via timeouts: bytes 1..16, 0x77, then a single marker
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
        repeat (10) tick();
        chk_gap = 1'b0;
        check("drain_q", exp_q.size(), 0);
        check("drain_level", level, 0);
        check("drain_ovf", ovf, 0);

        // Reset during WaitDone with five bytes queued
        mode = 2;
        tick();
        in_valid = 1'b1;
        in_byte = 8'h51;
        exp_q.push_back(8'h51);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_byte = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_level", level, 5);
        rst = 1'b0;
        mode = 0;
        #2;
        check("mid_rst_level", level, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_byte", tx_byte, 0);
        snap = n_start;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) tick();
        check("post_rst_starts", n_start, snap);
        check("post_rst_level", level, 0);
        check("post_rst_q", exp_q.size(), 0);

        in_valid = 1'b1;
        in_byte = 8'h99;
        exp_q.push_back(8'h99);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("final_starts", n_start, snap + 1);
        check("final_q", exp_q.size(), 0);
        check("final_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
